// File: rtl/reset_seq_ctrl_pkg.sv
// Shared types and helpers for the reset sequencing controller.
// Imported by the interface, the timer and the controller top.
package reset_seq_pkg;

   typedef enum logic [2:0] {
      StAsserted = 3'd0,
      StDelay    = 3'd1,
      StWaitAck  = 3'd2,
      StRun      = 3'd3,
      StError    = 3'd4
   } state_e;

   // Index width that stays legal (>= 1) for a single-stage bank.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : int'($clog2(n));
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/reset_seq_ctrl_if.sv
// Request/ack inputs and reset conduit/status outputs of the reset sequencer.
// master = system/test side, slave = controller side.
interface reset_seq_if #(
   parameter int unsigned NUM_STAGES = 4
);
   localparam int unsigned IDX_W = reset_seq_pkg::clog2_min1(NUM_STAGES);

   logic                  seq_req;
   logic [NUM_STAGES-1:0] stage_ack;
   logic [NUM_STAGES-1:0] reset_out_n;
   logic [IDX_W-1:0]      stage_idx;
   logic                  seq_busy;
   logic                  seq_done;
   logic                  seq_error;

   modport master (
      output seq_req, stage_ack,
      input  reset_out_n, stage_idx, seq_busy, seq_done, seq_error
   );

   modport slave (
      input  seq_req, stage_ack,
      output reset_out_n, stage_idx, seq_busy, seq_done, seq_error
   );
endinterface

// File: rtl/reset_seq_ctrl_timer.sv
// Saturating up-counter shared by the delay and ack-timeout phases.
// Clear wins over enable; the count stops at the terminal value and never wraps.
module reset_seq_timer #(
   parameter int unsigned CNT_W = 7
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] term_i,
   output logic             term_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != term_i)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign term_o = (cnt_q == term_i);
endmodule

// File: rtl/reset_seq_ctrl.sv
// Releases a bank of active-low reset conduits one stage at a time: fixed delay,
// then wait for the stage ack; a missing ack re-asserts everything and flags an error.
module reset_seq_ctrl import reset_seq_pkg::*; #(
   parameter int unsigned NUM_STAGES   = 4,
   parameter int unsigned DELAY_CYCLES = 16,
   parameter int unsigned ACK_TIMEOUT  = 64
) (
   input logic        clk,
   input logic        reset_n,
   reset_seq_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(max_u(DELAY_CYCLES, ACK_TIMEOUT) + 1);
   localparam int unsigned IDX_W = clog2_min1(NUM_STAGES);

   localparam logic [CNT_W-1:0] DelayTerm = CNT_W'(DELAY_CYCLES - 1);
   localparam logic [CNT_W-1:0] AckTerm   = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [IDX_W-1:0] LastIdx   = IDX_W'(NUM_STAGES - 1);

   state_e                state_q, state_d;
   logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  err_q, err_d;

   logic             tmr_clr, tmr_en, tmr_term;
   logic [CNT_W-1:0] tmr_lim;
   logic             ack_cur;

   assign tmr_lim = (state_q == StWaitAck) ? AckTerm : DelayTerm;
   assign ack_cur = bus.stage_ack[idx_q];

   reset_seq_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clr_i   (tmr_clr),
      .en_i    (tmr_en),
      .term_i  (tmr_lim),
      .term_o  (tmr_term)
   );

   always_comb begin
      state_d = state_q;
      rst_n_d = rst_n_q;
      idx_d   = idx_q;
      err_d   = err_q;
      tmr_clr = 1'b0;
      tmr_en  = 1'b0;

      // A held request overrides every state, including RUN and ERROR.
      if (bus.seq_req) begin
         state_d = StAsserted;
         rst_n_d = '0;
         idx_d   = '0;
         err_d   = 1'b0;
         tmr_clr = 1'b1;
      end else begin
         unique case (state_q)
            StAsserted: begin
               state_d = StDelay;
               idx_d   = '0;
               tmr_clr = 1'b1;
            end
            StDelay: begin
               if (tmr_term) begin
                  rst_n_d[idx_q] = 1'b1;
                  tmr_clr        = 1'b1;
                  state_d        = StWaitAck;
               end else begin
                  tmr_en = 1'b1;
               end
            end
            StWaitAck: begin
               // Ack is checked first so it beats a timeout on the same edge.
               if (ack_cur) begin
                  tmr_clr = 1'b1;
                  if (idx_q == LastIdx) begin
                     state_d = StRun;
                  end else begin
                     idx_d   = idx_q + IDX_W'(1);
                     state_d = StDelay;
                  end
               end else if (tmr_term) begin
                  rst_n_d = '0;
                  err_d   = 1'b1;
                  tmr_clr = 1'b1;
                  state_d = StError;
               end else begin
                  tmr_en = 1'b1;
               end
            end
            StRun, StError: begin
            end
            default: begin
               state_d = StAsserted;
               rst_n_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StAsserted;
         rst_n_q <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rst_n_q <= rst_n_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   assign bus.reset_out_n = rst_n_q;
   assign bus.stage_idx   = idx_q;
   assign bus.seq_busy    = (state_q == StDelay) || (state_q == StWaitAck);
   assign bus.seq_done    = (state_q == StRun);
   assign bus.seq_error   = err_q;
endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Bench for reset_seq_ctrl: an event-timeline model predicts when each output changes,
// a monitor pops those predictions whenever the DUT outputs actually change.
module tb_reset_seq_ctrl;
   import reset_seq_pkg::*;

   localparam int unsigned NS = 4;
   localparam int unsigned DC = 16;
   localparam int unsigned AT = 64;
   localparam int unsigned IW = clog2_min1(NS);

   typedef struct packed {
      logic [NS-1:0] rst;
      logic [IW-1:0] idx;
      logic          busy;
      logic          done;
      logic          err;
   } snap_t;

   typedef struct {
      int    edge_n;
      snap_t s;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;
   exp_t exp_q[$];
   snap_t mcur;

   reset_seq_if #(.NUM_STAGES(NS)) bus ();

   reset_seq_ctrl #(
      .NUM_STAGES   (NS),
      .DELAY_CYCLES (DC),
      .ACK_TIMEOUT  (AT)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic snap_t dut_snap();
      snap_t s;
      s.rst  = bus.reset_out_n;
      s.idx  = bus.stage_idx;
      s.busy = bus.seq_busy;
      s.done = bus.seq_done;
      s.err  = bus.seq_error;
      return s;
   endfunction

   function automatic void push_ev(input int e, input snap_t s);
      exp_t ev;
      if (s !== mcur) begin
         ev.edge_n = e;
         ev.s      = s;
         exp_q.push_back(ev);
         mcur = s;
      end
   endfunction

   // Monitor: every observed output change must match the next predicted event.
   initial begin : monitor
      snap_t cur, last;
      exp_t  e;
      last = '0;
      forever begin
         @(negedge clk);
         cur = dut_snap();
         if (!mon_en) begin
            last = cur;
         end else if (cur !== last) begin
            last = cur;
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_change: edge %0d got %h, required no change", cyc, cur);
            end else begin
               e = exp_q.pop_front();
               if (e.edge_n != cyc || cur !== e.s) begin
                  n_fail++;
                  $display("FAIL out_event: edge %0d snap %h, required edge %0d snap %h",
                           cyc, cur, e.edge_n, e.s);
               end
            end
         end
      end
   end

   // k[i]: edges after stage i release until its ack is sampled high; k > AT means never.
   // abort_at: offset from the start edge at which seq_req=1 is sampled (0 = none).
   task automatic run_seq(input int k[NS], input int abort_at, input bit noise);
      exp_t  evs[$];
      exp_t  ev;
      snap_t s;
      int    rel[NS];
      int    acc[NS];
      int    t, e0, last_e, end_e;

      @(negedge clk);
      bus.seq_req   = 1'b1;
      bus.stage_ack = '0;
      push_ev(cyc + 1, '0);
      @(negedge clk);
      bus.seq_req = 1'b0;
      e0 = cyc + 1;

      for (int i = 0; i < NS; i++) begin
         rel[i] = 0;
         acc[i] = 0;
      end
      s = '0;
      s.busy = 1'b1;
      ev.edge_n = e0; ev.s = s; evs.push_back(ev);
      t = e0;
      last_e = e0;
      for (int i = 0; i < NS; i++) begin
         rel[i] = t + int'(DC);
         s.rst[i] = 1'b1;
         ev.edge_n = rel[i]; ev.s = s; evs.push_back(ev);
         if (k[i] <= int'(AT)) begin
            acc[i] = rel[i] + k[i];
            t = acc[i];
            if (i == NS - 1) begin
               s.busy = 1'b0;
               s.done = 1'b1;
            end else begin
               s.idx = IW'(i + 1);
            end
         end else begin
            acc[i] = rel[i] + int'(AT);
            s.rst  = '0;
            s.err  = 1'b1;
            s.busy = 1'b0;
         end
         ev.edge_n = acc[i]; ev.s = s; evs.push_back(ev);
         last_e = acc[i];
         if (k[i] > int'(AT)) break;
      end

      foreach (evs[j]) begin
         if (abort_at == 0 || evs[j].edge_n < e0 + abort_at) push_ev(evs[j].edge_n, evs[j].s);
      end
      if (abort_at != 0) begin
         push_ev(e0 + abort_at, '0);
         end_e = e0 + abort_at;
      end else begin
         end_e = last_e + 3;
      end

      while (cyc < end_e) begin
         int            n;
         logic [NS-1:0] a;
         n = cyc + 1;
         a = noise ? NS'($urandom) : '1;
         for (int i = 0; i < NS; i++) begin
            if (n > rel[i] && n <= acc[i]) a[i] = (n == acc[i]) && (k[i] <= int'(AT));
         end
         bus.stage_ack = a;
         if (abort_at != 0 && n == end_e) bus.seq_req = 1'b1;
         @(negedge clk);
      end
      #1;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL events_missing: %0d pending, required 0 (next edge %0d)",
                  exp_q.size(), exp_q[0].edge_n);
         exp_q.delete();
      end
   endtask

   function automatic int pick_k();
      case ($urandom_range(0, 7))
         0:       return int'(AT) + 1;
         1:       return int'(AT);
         2:       return int'(AT) - 1;
         3:       return int'($urandom_range(1, AT));
         default: return int'($urandom_range(1, 6));
      endcase
   endfunction

   task automatic check_reset_snap(input string name);
      snap_t cur;
      cur = dut_snap();
      n_tests++;
      if (cur !== snap_t'('0)) begin
         n_fail++;
         $display("FAIL %s: snap %h, required %h", name, cur, snap_t'('0));
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int k[NS];
      reset_n       = 1'b0;
      bus.seq_req   = 1'b1;
      bus.stage_ack = '0;
      mcur          = '0;
      repeat (2) @(negedge clk);
      check_reset_snap("reset_values");
      reset_n = 1'b1;
      @(negedge clk);
      #1 mon_en = 1'b1;

      k = '{1, 1, 1, 1};
      run_seq(k, 0, 1'b0);
      k = '{1, 1, 65, 1};
      run_seq(k, 0, 1'b1);
      k = '{3, 1, 64, 5};
      run_seq(k, 0, 1'b1);
      k = '{1, 1, 1, 1};
      run_seq(k, 25, 1'b0);
      k = '{1, 1, 1, 1};
      run_seq(k, 0, 1'b1);

      // Async reset while in RUN: outputs must clear before the next clock edge.
      @(negedge clk);
      #1 mon_en = 1'b0;
      #2 reset_n = 1'b0;
      #1 check_reset_snap("async_reset");
      bus.seq_req = 1'b1;
      mcur = '0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1 mon_en = 1'b1;

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < NS; i++) k[i] = pick_k();
         run_seq(k, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 300)) : 0, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
